// File: rtl/disk_spin_animation.sv
// Single 7-segment "spinning disk": one outer segment lit, advancing one position
// every STEP_CYCLES clocks while Start is high, frozen while Start is low.
module disk_spin_animation #(
    parameter int STEP_CYCLES = 25000000,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter bit CLOCKWISE   = 1'b1
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       Start,
    output logic [7:0] SSeg
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        SA = 3'd0,
        SB = 3'd1,
        SC = 3'd2,
        SD = 3'd3,
        SE = 3'd4,
        SF = 3'd5
    } pos_t;

    pos_t          pos, pos_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          step;
    logic [7:0]    lit;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            cnt <= '0;
            pos <= SA;
        end else begin
            cnt <= cnt_nxt;
            pos <= pos_nxt;
        end
    end

    // A low Start clears the partial count so every resume waits a full period.
    always_comb begin
        step    = Start && (cnt == LAST);
        cnt_nxt = '0;
        pos_nxt = pos;
        if (Start && !step) begin
            cnt_nxt = cnt + 1'b1;
        end
        if (step) begin
            if (CLOCKWISE) begin
                case (pos)
                    SA:      pos_nxt = SB;
                    SB:      pos_nxt = SC;
                    SC:      pos_nxt = SD;
                    SD:      pos_nxt = SE;
                    SE:      pos_nxt = SF;
                    SF:      pos_nxt = SA;
                    default: pos_nxt = SB;
                endcase
            end else begin
                case (pos)
                    SA:      pos_nxt = SF;
                    SF:      pos_nxt = SE;
                    SE:      pos_nxt = SD;
                    SD:      pos_nxt = SC;
                    SC:      pos_nxt = SB;
                    SB:      pos_nxt = SA;
                    default: pos_nxt = SF;
                endcase
            end
        end
    end

    // Illegal encodings show segment a, matching the state they recover from.
    always_comb begin
        lit = 8'h01;
        case (pos)
            SA:      lit = 8'h01;
            SB:      lit = 8'h02;
            SC:      lit = 8'h04;
            SD:      lit = 8'h08;
            SE:      lit = 8'h10;
            SF:      lit = 8'h20;
            default: lit = 8'h01;
        endcase
        SSeg = ACTIVE_LOW ? ~lit : lit;
    end

endmodule

// File: tb/tb_disk_spin_animation.sv
// Directed bench for disk_spin_animation: reset hold, spin, pause, async reset,
// counter-clockwise single-cycle stepping and active-high polarity.
module tb_disk_spin_animation;

    logic       clk;
    logic       n_reset;
    logic       start;
    logic [7:0] sseg;

    logic       ccw_n_reset;
    logic       ccw_start;
    logic [7:0] ccw_sseg;

    logic [7:0] al0_sseg;

    logic [7:0] exp_q[$];
    int         checks;
    int         failures;
    logic [7:0] pat_cw[6];
    logic [7:0] pat_ccw[6];

    disk_spin_animation #(.STEP_CYCLES(3), .ACTIVE_LOW(1'b1), .CLOCKWISE(1'b1)) dut (
        .Clk(clk), .nReset(n_reset), .Start(start), .SSeg(sseg)
    );

    disk_spin_animation #(.STEP_CYCLES(1), .ACTIVE_LOW(1'b1), .CLOCKWISE(1'b0)) dut_ccw (
        .Clk(clk), .nReset(ccw_n_reset), .Start(ccw_start), .SSeg(ccw_sseg)
    );

    disk_spin_animation #(.STEP_CYCLES(3), .ACTIVE_LOW(1'b0), .CLOCKWISE(1'b1)) dut_al0 (
        .Clk(clk), .nReset(n_reset), .Start(start), .SSeg(al0_sseg)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pat_cw   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};
        pat_ccw  = '{8'hFE, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD};

        n_reset     = 1'b0;
        start       = 1'b1;
        ccw_n_reset = 1'b0;
        ccw_start   = 1'b1;

        // reset held with Start high: display stays on segment a
        #2;
        expect_val(8'hFE); check("reset_initial", sseg);
        expect_val(8'h01); check("al0_reset", al0_sseg);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_val(8'hFE); check("reset_hold", sseg);
        end

        // spin: each pattern held for 3 edges, full revolution plus wrap
        n_reset = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            tick();
            expect_val(pat_cw[(e / 3) % 6]); check("spin", sseg);
            if (e == 3) begin
                expect_val(8'h02); check("al0_first_step", al0_sseg);
            end
        end

        // pause on FB for 10 edges, then a full period to F7
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_val(8'hFB); check("pause_hold", sseg);
        end
        start = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            expect_val(e < 3 ? 8'hFB : 8'hF7); check("pause_resume", sseg);
        end

        // advance to EF, then assert reset between edges
        for (int e = 1; e <= 3; e++) begin
            tick();
            expect_val(e < 3 ? 8'hF7 : 8'hEF); check("pre_async", sseg);
        end
        #3;
        n_reset = 1'b0;
        #1;
        expect_val(8'hFE); check("async_reset", sseg);
        tick();
        expect_val(8'hFE); check("async_reset_held", sseg);
        n_reset = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            expect_val(e < 3 ? 8'hFE : 8'hFD); check("after_release", sseg);
        end

        // partial count discarded by a one-cycle pause
        for (int e = 1; e <= 2; e++) begin
            tick();
            expect_val(8'hFD); check("partial_count", sseg);
        end
        start = 1'b0;
        tick();
        expect_val(8'hFD); check("partial_pause", sseg);
        start = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            expect_val(e < 3 ? 8'hFD : 8'hFB); check("partial_resume", sseg);
        end

        // counter-clockwise, one edge per step
        expect_val(8'hFE); check("ccw_reset", ccw_sseg);
        ccw_n_reset = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            expect_val(pat_ccw[e % 6]); check("ccw_spin", ccw_sseg);
        end
        ccw_start = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            tick();
            expect_val(pat_ccw[1]); check("ccw_pause", ccw_sseg);
        end

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL leftover_expectations observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
